// File: rtl/pool_layer.sv
// 2x2 stride-2 signed max-pooling engine. Streams four reads per window
// through the shared load/DMA port, writes the window maximum, and raises
// done once every window of every image has been written back.
module pool_layer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] imagesCount,
  input  logic [ADDR_W-1:0] imgSize,
  input  logic [ADDR_W-1:0] address,
  output logic              done,
  output logic              loadImgEnable,
  output logic [ADDR_W-1:0] loadImgAddrr,
  output logic              RW,
  input  logic [DATA_W-1:0] image,
  output logic [DATA_W-1:0] poolOut,
  input  logic              opDone
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    WR,
    FIN
  } state_t;

  state_t state_q;

  // Registered port values
  logic              done_q;
  logic              enable_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] poolOut_q;

  // Job geometry captured when leaving IDLE
  logic [ADDR_W-1:0] side_q;
  logic [ADDR_W-1:0] area_q;
  logic [ADDR_W-1:0] outLast_q;
  logic [ADDR_W-1:0] countLast_q;

  // Window position: counters plus matching address pointers, so that no
  // multiplier is needed while walking the images
  logic [ADDR_W-1:0] i_q, j_q, k_q;
  logic [ADDR_W-1:0] imgPtr_q, rowPtr_q, winPtr_q, wrPtr_q;

  // Running maximum of the current window
  logic [DATA_W-1:0] max_q;

  // Next-window values
  logic [ADDR_W-1:0] i_d, j_d, k_d;
  logic [ADDR_W-1:0] imgPtr_d, rowPtr_d, winPtr_d;
  logic              lastWin_d;

  logic [ADDR_W-1:0] imgAreaIn;
  logic [ADDR_W-1:0] outBaseIn;
  logic              jobValid;
  logic              greater;
  logic [DATA_W-1:0] rdMax;

  assign done          = done_q;
  assign loadImgEnable = enable_q;
  assign loadImgAddrr  = addr_q;
  assign RW            = rw_q;
  assign poolOut       = poolOut_q;

  // Output area starts right after the last input image (wraps modulo 2^16)
  assign imgAreaIn = imgSize * imgSize;
  assign outBaseIn = address + imagesCount * imgAreaIn;
  assign jobValid  = (imagesCount != '0) && (imgSize >= TWO);

  // Signed compare; a tie keeps the value already held
  assign greater = $signed(image) > $signed(max_q);
  assign rdMax   = greater ? image : max_q;

  // Step to the next window: column, then row pair, then image. Stepping an
  // image restarts from the image base, which skips a dropped odd last row.
  always_comb begin
    j_d       = j_q + ONE;
    i_d       = i_q;
    k_d       = k_q;
    imgPtr_d  = imgPtr_q;
    rowPtr_d  = rowPtr_q;
    winPtr_d  = winPtr_q + TWO;
    lastWin_d = 1'b0;
    if (j_q == outLast_q) begin
      j_d = '0;
      if (i_q == outLast_q) begin
        i_d       = '0;
        k_d       = k_q + ONE;
        imgPtr_d  = imgPtr_q + area_q;
        rowPtr_d  = imgPtr_d;
        winPtr_d  = imgPtr_d;
        lastWin_d = (k_q == countLast_q);
      end else begin
        i_d      = i_q + ONE;
        rowPtr_d = rowPtr_q + (side_q << 1);
        winPtr_d = rowPtr_d;
      end
    end
  end

  // Control FSM: sequences the four reads and one write per window and
  // drives every memory-port output from registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      enable_q    <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      poolOut_q   <= '0;
      side_q      <= '0;
      area_q      <= '0;
      outLast_q   <= '0;
      countLast_q <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      imgPtr_q    <= '0;
      rowPtr_q    <= '0;
      winPtr_q    <= '0;
      wrPtr_q     <= '0;
      max_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            side_q      <= imgSize;
            area_q      <= imgAreaIn;
            outLast_q   <= (imgSize >> 1) - ONE;
            countLast_q <= imagesCount - ONE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            imgPtr_q    <= address;
            rowPtr_q    <= address;
            winPtr_q    <= address;
            wrPtr_q     <= outBaseIn;
            if (jobValid) begin
              enable_q <= 1'b1;
              rw_q     <= 1'b0;
              addr_q   <= address;
              state_q  <= RD0;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        RD0: begin
          if (opDone) begin
            max_q   <= image;
            addr_q  <= winPtr_q + ONE;
            state_q <= RD1;
          end
        end
        RD1: begin
          if (opDone) begin
            max_q   <= rdMax;
            addr_q  <= winPtr_q + side_q;
            state_q <= RD2;
          end
        end
        RD2: begin
          if (opDone) begin
            max_q   <= rdMax;
            addr_q  <= winPtr_q + side_q + ONE;
            state_q <= RD3;
          end
        end
        RD3: begin
          if (opDone) begin
            max_q     <= rdMax;
            poolOut_q <= rdMax;
            rw_q      <= 1'b1;
            addr_q    <= wrPtr_q;
            state_q   <= WR;
          end
        end
        WR: begin
          if (opDone) begin
            rw_q     <= 1'b0;
            wrPtr_q  <= wrPtr_q + ONE;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            imgPtr_q <= imgPtr_d;
            rowPtr_q <= rowPtr_d;
            winPtr_q <= winPtr_d;
            if (lastWin_d) begin
              enable_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= FIN;
            end else begin
              addr_q  <= winPtr_d;
              state_q <= RD0;
            end
          end
        end
        FIN: begin
          if (!enable) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          done_q   <= 1'b0;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_layer.sv
// Directed bench for pool_layer: a word-addressed memory with optional
// wait states answers the access port, every completed access is logged,
// and the log is compared against hand-computed addresses and maxima.
module tb_pool_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] imagesCount;
  logic [15:0] imgSize;
  logic [15:0] address;
  logic        done;
  logic        loadImgEnable;
  logic [15:0] loadImgAddrr;
  logic        RW;
  logic [15:0] image;
  logic [15:0] poolOut;
  logic        opDone;

  int checks = 0;
  int errors = 0;

  int waits = 0;
  logic [15:0] mem [0:1023];

  int busyCnt = 0;
  int accCount = 0;
  int wrCount = 0;
  int stabErr = 0;
  int outOfRange = 0;
  logic [15:0] accAddrLog [0:1023];
  logic        accRwLog   [0:1023];
  logic [15:0] wrAddrLog  [0:255];
  logic [15:0] wrDataLog  [0:255];
  logic        holdValid = 1'b0;
  logic [15:0] holdAddr;
  logic        holdRw;
  logic [15:0] holdData;

  always #5 clk = ~clk;

  pool_layer #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .imagesCount  (imagesCount),
    .imgSize      (imgSize),
    .address      (address),
    .done         (done),
    .loadImgEnable(loadImgEnable),
    .loadImgAddrr (loadImgAddrr),
    .RW           (RW),
    .image        (image),
    .poolOut      (poolOut),
    .opDone       (opDone)
  );

  // Memory answers combinationally; with waits=0 the acknowledge is tied high
  assign image  = mem[loadImgAddrr[9:0]];
  assign opDone = (waits == 0) ? 1'b1 : (loadImgEnable && (busyCnt >= waits));

  // Access monitor: counts wait cycles, logs completed accesses, and
  // watches that a pending access holds its address/RW/data
  always @(posedge clk) begin
    if (reset || !loadImgEnable || opDone) busyCnt <= 0;
    else busyCnt <= busyCnt + 1;
    if (!reset && loadImgEnable) begin
      if (holdValid && (loadImgAddrr !== holdAddr || RW !== holdRw || poolOut !== holdData))
        stabErr <= stabErr + 1;
      if (opDone) begin
        holdValid <= 1'b0;
        accAddrLog[accCount & 1023] <= loadImgAddrr;
        accRwLog[accCount & 1023]   <= RW;
        accCount <= accCount + 1;
        if (loadImgAddrr >= 16'd1024) outOfRange <= outOfRange + 1;
        if (RW) begin
          wrAddrLog[wrCount & 255] <= loadImgAddrr;
          wrDataLog[wrCount & 255] <= poolOut;
          wrCount <= wrCount + 1;
        end
      end else begin
        holdValid <= 1'b1;
        holdAddr  <= loadImgAddrr;
        holdRw    <= RW;
        holdData  <= poolOut;
      end
    end else begin
      holdValid <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts one job and counts cycles until done is seen; optionally drops
  // enable and scrambles the job inputs right after the start
  task automatic applyStimulus(input int cnt, input int sz, input int base,
                               input int w, input bit dropEnable,
                               output int cycles);
    @(negedge clk);
    waits       = w;
    imagesCount = 16'(cnt);
    imgSize     = 16'(sz);
    address     = 16'(base);
    enable      = 1'b1;
    cycles      = 0;
    while (cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (dropEnable && cycles == 1) begin
        enable      = 1'b0;
        imagesCount = 16'd9;
        imgSize     = 16'd7;
        address     = 16'd999;
      end
      if (done) break;
    end
    checkOutput("doneSeen", {31'd0, done}, 32'd1);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] max4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    logic signed [15:0] m;
    m = a;
    if ($signed(b) > m) m = b;
    if ($signed(c) > m) m = c;
    if ($signed(d) > m) m = d;
    return m;
  endfunction

  initial begin
    int cyc;
    int aBase;
    int wBase;
    int sBase;
    int oBase;
    int hits;
    int maxAddr;
    int n;
    int r;
    int c;
    int adr;
    logic [15:0] e;
    logic [15:0] exp4 [0:3];

    reset = 1'b1;
    enable = 1'b0;
    imagesCount = '0;
    imgSize = '0;
    address = '0;
    for (int p = 0; p < 1024; p++) mem[p] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {12'd0, done, loadImgEnable, RW, poolOut, loadImgAddrr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterReset", {30'd0, done, loadImgEnable}, 32'd0);

    // One 4x4 image holding 0..15
    for (int p = 0; p < 16; p++) mem[p] = 16'(p);
    aBase = accCount;
    wBase = wrCount;
    applyStimulus(1, 4, 0, 0, 1'b0, cyc);
    checkOutput("s4_cycles", cyc, 32'd21);
    checkOutput("s4_accesses", accCount - aBase, 32'd20);
    checkOutput("s4_acc0", {accRwLog[(aBase) & 1023], accAddrLog[(aBase) & 1023]}, {1'b0, 16'd0});
    checkOutput("s4_acc1", {accRwLog[(aBase + 1) & 1023], accAddrLog[(aBase + 1) & 1023]}, {1'b0, 16'd1});
    checkOutput("s4_acc2", {accRwLog[(aBase + 2) & 1023], accAddrLog[(aBase + 2) & 1023]}, {1'b0, 16'd4});
    checkOutput("s4_acc3", {accRwLog[(aBase + 3) & 1023], accAddrLog[(aBase + 3) & 1023]}, {1'b0, 16'd5});
    checkOutput("s4_acc4", {accRwLog[(aBase + 4) & 1023], accAddrLog[(aBase + 4) & 1023]}, {1'b1, 16'd16});
    checkOutput("s4_writes", wrCount - wBase, 32'd4);
    exp4[0] = 16'd5; exp4[1] = 16'd7; exp4[2] = 16'd13; exp4[3] = 16'd15;
    for (int q = 0; q < 4; q++)
      checkOutput($sformatf("s4_out%0d", q),
                  {wrAddrLog[(wBase + q) & 255], wrDataLog[(wBase + q) & 255]},
                  {16'(16 + q), exp4[q]});

    // Signed windows, 4x4 image at base 100
    mem[100] = 16'hFFFD; mem[101] = 16'hFFFF; mem[104] = 16'hFFF8; mem[105] = 16'hFFFE;
    mem[102] = 16'h8000; mem[103] = 16'h7FFF; mem[106] = 16'h0000; mem[107] = 16'h0001;
    mem[108] = 16'h8000; mem[109] = 16'h8000; mem[112] = 16'h8000; mem[113] = 16'h8000;
    mem[110] = 16'h0005; mem[111] = 16'hFFF9; mem[114] = 16'h0005; mem[115] = 16'h0002;
    wBase = wrCount;
    applyStimulus(1, 4, 100, 0, 1'b0, cyc);
    exp4[0] = 16'hFFFF; exp4[1] = 16'h7FFF; exp4[2] = 16'h8000; exp4[3] = 16'h0005;
    for (int q = 0; q < 4; q++)
      checkOutput($sformatf("signed_out%0d", q),
                  {wrAddrLog[(wBase + q) & 255], wrDataLog[(wBase + q) & 255]},
                  {16'(116 + q), exp4[q]});

    // Three wait cycles per access, 2x2 image at base 200
    mem[200] = 16'd10; mem[201] = 16'hFFEC; mem[202] = 16'd30; mem[203] = 16'd4;
    aBase = accCount;
    wBase = wrCount;
    sBase = stabErr;
    applyStimulus(1, 2, 200, 3, 1'b0, cyc);
    waits = 0;
    checkOutput("wait_cycles", cyc, 32'd21);
    checkOutput("wait_accesses", accCount - aBase, 32'd5);
    checkOutput("wait_stable", stabErr - sBase, 32'd0);
    checkOutput("wait_write", {wrAddrLog[wBase & 255], wrDataLog[wBase & 255]}, {16'd204, 16'd30});

    // Degenerate jobs finish at once without touching memory
    aBase = accCount;
    applyStimulus(0, 4, 0, 0, 1'b0, cyc);
    checkOutput("count0_cycles", cyc, 32'd1);
    checkOutput("count0_accesses", accCount - aBase, 32'd0);
    aBase = accCount;
    applyStimulus(2, 1, 0, 0, 1'b0, cyc);
    checkOutput("size1_cycles", cyc, 32'd1);
    checkOutput("size1_accesses", accCount - aBase, 32'd0);

    // Odd side 5 at base 300; enable dropped and inputs scrambled after start
    for (int rr = 0; rr < 5; rr++)
      for (int cc = 0; cc < 5; cc++)
        mem[300 + rr * 5 + cc] = (rr < 4 && cc < 4) ? 16'(rr * 5 + cc) : 16'h7FFF;
    aBase = accCount;
    wBase = wrCount;
    applyStimulus(1, 5, 300, 0, 1'b1, cyc);
    checkOutput("s5_cycles", cyc, 32'd21);
    checkOutput("s5_writes", wrCount - wBase, 32'd4);
    hits = 0;
    for (int q = aBase; q < accCount; q++) begin
      adr = int'(accAddrLog[q & 1023]);
      if (!accRwLog[q & 1023] && adr >= 300 && adr < 325) begin
        r = (adr - 300) / 5;
        c = (adr - 300) % 5;
        if (r == 4 || c == 4) hits++;
      end
    end
    checkOutput("s5_edgeReads", hits, 32'd0);
    exp4[0] = 16'd6; exp4[1] = 16'd8; exp4[2] = 16'd16; exp4[3] = 16'd18;
    for (int q = 0; q < 4; q++)
      checkOutput($sformatf("s5_out%0d", q),
                  {wrAddrLog[(wBase + q) & 255], wrDataLog[(wBase + q) & 255]},
                  {16'(325 + q), exp4[q]});

    // Reset in the middle of a job, then a fresh start from image 0
    @(negedge clk);
    imagesCount = 16'd1; imgSize = 16'd4; address = 16'd0; enable = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midReset_outputs", {12'd0, done, loadImgEnable, RW, poolOut, loadImgAddrr}, 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    aBase = accCount;
    repeat (6) @(negedge clk);
    checkOutput("midReset_noAccess", accCount - aBase, 32'd0);
    aBase = accCount;
    wBase = wrCount;
    applyStimulus(1, 4, 0, 0, 1'b0, cyc);
    checkOutput("restart_cycles", cyc, 32'd21);
    checkOutput("restart_first", {accRwLog[aBase & 1023], accAddrLog[aBase & 1023]}, {1'b0, 16'd0});
    exp4[0] = 16'd5; exp4[1] = 16'd7; exp4[2] = 16'd13; exp4[3] = 16'd15;
    for (int q = 0; q < 4; q++)
      checkOutput($sformatf("restart_out%0d", q),
                  {wrAddrLog[(wBase + q) & 255], wrDataLog[(wBase + q) & 255]},
                  {16'(16 + q), exp4[q]});

    // Three 14x14 images at base 0 with scrambled signed data
    for (int p = 0; p < 588; p++) mem[p] = 16'((p * 40503) >> 3) ^ 16'(p);
    for (int p = 588; p < 1024; p++) mem[p] = '0;
    aBase = accCount;
    wBase = wrCount;
    oBase = outOfRange;
    applyStimulus(3, 14, 0, 0, 1'b0, cyc);
    checkOutput("s14_cycles", cyc, 32'd736);
    checkOutput("s14_writes", wrCount - wBase, 32'd147);
    checkOutput("s14_accesses", accCount - aBase, 32'd735);
    checkOutput("s14_outOfRange", outOfRange - oBase, 32'd0);
    maxAddr = 0;
    for (int q = aBase; q < accCount; q++)
      if (int'(accAddrLog[q & 1023]) > maxAddr) maxAddr = int'(accAddrLog[q & 1023]);
    checkOutput("s14_maxAddr", maxAddr, 32'd734);
    n = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7; j++) begin
          adr = k * 196 + 2 * i * 14 + 2 * j;
          e = max4(mem[adr], mem[adr + 1], mem[adr + 14], mem[adr + 15]);
          checkOutput($sformatf("s14_pix%0d", n),
                      {wrAddrLog[(wBase + n) & 255], wrDataLog[(wBase + n) & 255]},
                      {16'(588 + n), e});
          n++;
        end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
